// File: rtl/qdrc_arb.sv
// Two-requester QDR II command scheduler: independent round-robin write and read slots,
// plus a tag FIFO that steers returned read data back to the requester that issued the read.
module qdrc_arb #(
  parameter int DATA_WIDTH = 36,
  parameter int BW_WIDTH   = 4,
  parameter int ADDR_WIDTH = 21,
  parameter int TAG_DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    phy_rdy,

  input  logic                    a_req,
  input  logic                    a_we,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [2*DATA_WIDTH-1:0] a_data,
  input  logic [2*BW_WIDTH-1:0]   a_ben,
  output logic                    a_ack,
  output logic                    a_rd_dvld,
  output logic [2*DATA_WIDTH-1:0] a_rd_data,

  input  logic                    b_req,
  input  logic                    b_we,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [2*DATA_WIDTH-1:0] b_data,
  input  logic [2*BW_WIDTH-1:0]   b_ben,
  output logic                    b_ack,
  output logic                    b_rd_dvld,
  output logic [2*DATA_WIDTH-1:0] b_rd_data,

  output logic                    qdr_wr_strb,
  output logic [ADDR_WIDTH-1:0]   qdr_wr_addr,
  output logic [2*DATA_WIDTH-1:0] qdr_wr_data,
  output logic [2*BW_WIDTH-1:0]   qdr_wr_ben,
  output logic                    qdr_rd_strb,
  output logic [ADDR_WIDTH-1:0]   qdr_rd_addr,
  input  logic                    qdr_rd_dvld,
  input  logic [2*DATA_WIDTH-1:0] qdr_rd_data,
  output logic                    rd_err
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Round-robin pointers: 0 designates A, 1 designates B.
  logic                 wr_ptr;
  logic                 rd_ptr;

  logic [TAG_DEPTH-1:0] tag_mem;
  logic [PTR_W-1:0]     tag_wr_idx;
  logic [PTR_W-1:0]     tag_rd_idx;
  logic [CNT_W-1:0]     tag_cnt;

  logic a_wc, b_wc, a_rc, b_rc;
  logic rd_room;
  logic wr_gnt, wr_sel_b;
  logic rd_gnt, rd_sel_b;
  logic tag_push, tag_pop, tag_head;

  // Read eligibility uses the registered count, so a same-cycle pop cannot reopen a full FIFO.
  always_comb begin
    rd_room  = (tag_cnt < CNT_W'(TAG_DEPTH));

    a_wc     = phy_rdy & a_req & a_we;
    b_wc     = phy_rdy & b_req & b_we;
    a_rc     = phy_rdy & rd_room & a_req & ~a_we;
    b_rc     = phy_rdy & rd_room & b_req & ~b_we;

    wr_gnt   = a_wc | b_wc;
    wr_sel_b = b_wc & (~a_wc | wr_ptr);
    rd_gnt   = a_rc | b_rc;
    rd_sel_b = b_rc & (~a_rc | rd_ptr);

    a_ack    = (wr_gnt & ~wr_sel_b) | (rd_gnt & ~rd_sel_b);
    b_ack    = (wr_gnt &  wr_sel_b) | (rd_gnt &  rd_sel_b);

    tag_push = rd_gnt;
    tag_pop  = qdr_rd_dvld & (tag_cnt != '0);
    tag_head = tag_mem[tag_rd_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= 1'b0;
      qdr_wr_strb <= 1'b0;
      qdr_wr_addr <= '0;
      qdr_wr_data <= '0;
      qdr_wr_ben  <= '0;
    end else begin
      qdr_wr_strb <= wr_gnt;
      if (wr_gnt) begin
        wr_ptr      <= ~wr_sel_b;
        qdr_wr_addr <= wr_sel_b ? b_addr : a_addr;
        qdr_wr_data <= wr_sel_b ? b_data : a_data;
        qdr_wr_ben  <= wr_sel_b ? b_ben  : a_ben;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr      <= 1'b0;
      qdr_rd_strb <= 1'b0;
      qdr_rd_addr <= '0;
    end else begin
      qdr_rd_strb <= rd_gnt;
      if (rd_gnt) begin
        rd_ptr      <= ~rd_sel_b;
        qdr_rd_addr <= rd_sel_b ? b_addr : a_addr;
      end
    end
  end

  // Tag FIFO: one bit per outstanding read, 0 = A, 1 = B.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_mem    <= '0;
      tag_wr_idx <= '0;
      tag_rd_idx <= '0;
      tag_cnt    <= '0;
    end else begin
      if (tag_push) begin
        tag_mem[tag_wr_idx] <= rd_sel_b;
        tag_wr_idx          <= tag_wr_idx + 1'b1;
      end
      if (tag_pop)
        tag_rd_idx <= tag_rd_idx + 1'b1;
      case ({tag_push, tag_pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  // A return with nothing outstanding is flagged and otherwise swallowed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rd_dvld <= 1'b0;
      b_rd_dvld <= 1'b0;
      a_rd_data <= '0;
      b_rd_data <= '0;
      rd_err    <= 1'b0;
    end else begin
      a_rd_dvld <= tag_pop & ~tag_head;
      b_rd_dvld <= tag_pop &  tag_head;
      if (qdr_rd_dvld) begin
        a_rd_data <= qdr_rd_data;
        b_rd_data <= qdr_rd_data;
      end
      if (qdr_rd_dvld && (tag_cnt == '0))
        rd_err <= 1'b1;
    end
  end

endmodule

// File: doc/qdrc_arb.md
Name: qdrc_arb

Overview:
- Two-requester scheduler sitting in front of the QDR controller's write and read paths.
- QDR II accepts one write and one read per cycle, so the block arbitrates a write slot and a read slot independently each cycle.
- Each slot uses fair round-robin between requester A and requester B.
- The block tracks outstanding reads in a tag FIFO and steers returned read data to the requester that issued each read.
- No commands are issued until the PHY reports calibration complete.

Parameters:
- DATA_WIDTH, 36, QDR data width per beat; bursts are 2 beats.
- BW_WIDTH, 4, byte-enable width per beat.
- ADDR_WIDTH, 21, QDR burst address width.
- TAG_DEPTH, 16, maximum outstanding reads; must be a power of two.

Ports:
- clk  in  1  controller clock.
- reset  in  1  asynchronous, active-high.
- phy_rdy  in  1  PHY calibration done.
- a_req  in  1  requester A command valid.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  ADDR_WIDTH  burst address.
- a_data  in  2*DATA_WIDTH  write data.
- a_ben  in  2*BW_WIDTH  write byte enables.
- a_ack  out  1  command accepted this cycle.
- a_rd_dvld  out  1  read data valid for A.
- a_rd_data  out  2*DATA_WIDTH  read data for A.
- b_req, b_we, b_addr, b_data, b_ben, b_ack, b_rd_dvld, b_rd_data  same as the A ports, for requester B.
- qdr_wr_strb  out  1  write issue.
- qdr_wr_addr  out  ADDR_WIDTH  write address.
- qdr_wr_data  out  2*DATA_WIDTH  write data.
- qdr_wr_ben  out  2*BW_WIDTH  write byte enables.
- qdr_rd_strb  out  1  read issue.
- qdr_rd_addr  out  ADDR_WIDTH  read address.
- qdr_rd_dvld  in  1  read data returned from the controller.
- qdr_rd_data  in  2*DATA_WIDTH  returned read data.
- rd_err  out  1  sticky: qdr_rd_dvld arrived while the tag FIFO was empty.

Behaviour:
- Reset:
  - All strobes, acks, dvld outputs and rd_err are 0.
  - Data and address outputs are 0.
  - Both round-robin pointers point to A.
  - Tag FIFO is empty with count 0.
- Gating: while phy_rdy is 0, no acks are given and no strobes are issued. Requests simply wait.
- Handshake:
  - A requester holds req and its fields stable until it sees ack.
  - ack is combinational in the grant cycle.
  - The requester may change fields or present a new command in the cycle after ack.
- Write slot:
  - Candidates are requesters with req=1 and we=1.
  - One candidate: it wins.
  - Two candidates: the one the write pointer designates wins.
  - After a grant the write pointer moves to the other requester. It is unchanged when there is no grant.
- Read slot:
  - Same round-robin rule with its own independent pointer; candidates have req=1 and we=0.
  - A read is eligible only when tag count < TAG_DEPTH.
- Concurrency: A-write and B-read, or A-read and B-write, are both granted in the same cycle.
- Issue latency: the granted command appears on the qdr_wr_* / qdr_rd_* outputs, registered, exactly 1 cycle after ack. The strobe is high for that single cycle.
- Tag FIFO:
  - Each read issue pushes a 1-bit tag (0 = A, 1 = B).
  - Each qdr_rd_dvld pops one tag.
  - Push and pop in the same cycle leave the count unchanged.
  - Count width is log2(TAG_DEPTH)+1.
  - Pointers wrap modulo TAG_DEPTH.
- Read return:
  - Registered, 1 cycle after qdr_rd_dvld.
  - The popped tag selects which of a_rd_dvld / b_rd_dvld pulses. The other stays 0.
  - qdr_rd_data is copied to both a_rd_data and b_rd_data.
- Error:
  - qdr_rd_dvld while the FIFO is empty sets rd_err. It stays set until reset.
  - No dvld pulse is produced for that beat and the count does not underflow.
- Full FIFO: with count == TAG_DEPTH and a pop in the current cycle, the read slot still stays blocked this cycle (eligibility uses the registered count). The slot reopens the next cycle.
- Mid-operation drop: if phy_rdy falls mid-stream, new issues stop. Outstanding tags are retained and returns are still routed.

Test Plan:
- Reset, then phy_rdy=0 with a_req=1, a_we=1 for 10 cycles -> no a_ack, qdr_wr_strb stays 0. Raise phy_rdy -> a_ack in that cycle, qdr_wr_strb one cycle later carrying a_addr/a_data/a_ben.
- A and B both write continuously for 6 cycles -> acks alternate A, B, A, B, A, B starting with A. qdr_wr_addr alternates to match.
- A reads addr 0x10 while B writes addr 0x20 in the same cycle -> both acked. Next cycle qdr_rd_strb and qdr_wr_strb both high, with the correct addresses.
- Issue reads A, B, B, A, then return 4 qdr_rd_dvld beats with data 1, 2, 3, 4 -> pulses a_rd_dvld(1), b_rd_dvld(2), b_rd_dvld(3), a_rd_dvld(4), each 1 cycle after its input beat.
- A issues 16 reads with no returns -> the 17th read is not acked. One dvld return -> the read is acked the cycle after the count decrements.
- qdr_rd_dvld with the FIFO empty -> rd_err=1 and no dvld outputs. Assert reset mid-stream -> rd_err=0, count=0, and outputs clear immediately (asynchronous).
